// File: rtl/stack_io_pkg.sv
// stack_io_pkg: word width and word type shared by the stack processor I/O ports
package stack_io_pkg;
  localparam int WORD_W = 16;
  typedef logic [WORD_W-1:0] word_t;
endpackage

// File: rtl/stack_out_port.sv
// stack_out_port: OUT-instruction transmit FIFO with valid/ready drain and sticky overflow
module stack_out_port
  import stack_io_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  output logic                     full,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     clr_ovf
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic ovf_q, ovf_d;
  logic push, pop, drop;
  assign full = count_q == CW'(DEPTH);
  assign out_valid = count_q != '0;
  assign out_data = mem_q[rd_ptr_q];
  assign count = count_q;
  assign overflow = ovf_q;
  // a full FIFO still accepts a write when the head leaves in the same cycle
  always_comb begin
    pop = out_valid & out_ready;
    push = wr_en & (~full | pop);
    drop = wr_en & full & ~pop;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d = count_q + CW'(push) - CW'(pop);
    ovf_d = drop | (ovf_q & ~clr_ovf);
  end
  // storage is never cleared; stale entries are masked by count
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end
  // pointer, occupancy and overflow state
  always_ff @(posedge CLK) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      ovf_q <= ovf_d;
    end
  end
endmodule

// File: tb/tb_stack_out_port.sv
// tb_stack_out_port: queue-model scoreboard plus directed scenarios for stack_out_port
module tb_stack_out_port;
  localparam int DEPTH = 4;
  logic CLK = 0, reset = 1, wr_en = 0, out_ready = 0, clr_ovf = 0;
  logic [15:0] wr_data = 0, out_data;
  logic full, out_valid, overflow;
  logic [2:0] count;
  int passed = 0, total = 0;
  bit chk_en = 0;
  logic [15:0] mq[$];
  logic [15:0] seen[$];
  bit movf = 0;

  stack_out_port #(.WIDTH(16), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .full(full),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .count(count), .overflow(overflow), .clr_ovf(clr_ovf)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    else passed++;
  endtask

  // reference: a plain queue obeying the accept/drop rules, plus the words the DUT hands over
  always @(posedge CLK) begin
    bit p, f, w, d;
    if (out_valid && out_ready) seen.push_back(out_data);
    if (reset) begin
      mq.delete();
      movf = 0;
    end else begin
      p = mq.size() > 0 && out_ready;
      f = mq.size() == DEPTH;
      w = wr_en && (!f || p);
      d = wr_en && f && !p;
      if (p) void'(mq.pop_front());
      if (w) mq.push_back(wr_data);
      movf = d || (movf && !clr_ovf);
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("count", 32'(count), 32'(mq.size()));
      chk("full", 32'(full), 32'(mq.size() == DEPTH));
      chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
      chk("overflow", 32'(overflow), 32'(movf));
      if (mq.size() != 0) chk("out_data", 32'(out_data), 32'(mq[0]));
    end
  end

  task automatic step(input logic we, input logic [15:0] d, input logic rdy, input logic clr, input logic rst);
    wr_en = we; wr_data = d; out_ready = rdy; clr_ovf = clr; reset = rst;
    @(negedge CLK);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(0, 16'h0, rdy, 0, 0);
  endtask

  initial begin
    @(negedge CLK);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    chk_en = 1;
    chk("rst_count", 32'(count), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_ovf", 32'(overflow), 0);
    seen.delete();
    step(1, 16'h0002, 0, 0, 0);
    step(1, 16'h0003, 0, 0, 0);
    chk("t1_count", 32'(count), 2);
    chk("t1_valid", 32'(out_valid), 1);
    chk("t1_head", 32'(out_data), 32'h0002);
    idle(2, 1);
    chk("t1_drained", 32'(count), 0);
    chk("t1_nseen", 32'(seen.size()), 2);
    if (seen.size() == 2) begin
      chk("t1_w0", 32'(seen[0]), 32'h0002);
      chk("t1_w1", 32'(seen[1]), 32'h0003);
    end
    seen.delete();
    for (int i = 1; i <= 4; i++) step(1, 16'(i * 16'h1111), 0, 0, 0);
    step(1, 16'h5555, 0, 0, 0);
    chk("t2_full", 32'(full), 1);
    chk("t2_ovf", 32'(overflow), 1);
    chk("t2_count", 32'(count), 4);
    idle(4, 1);
    chk("t2_nseen", 32'(seen.size()), 4);
    if (seen.size() == 4)
      for (int i = 0; i < 4; i++) chk("t2_word", 32'(seen[i]), 32'((i + 1) * 16'h1111));
    step(0, 0, 0, 1, 0);
    chk("t3_ovf_clr", 32'(overflow), 0);
    seen.delete();
    for (int i = 1; i <= 4; i++) step(1, 16'h0A00 + 16'(i), 0, 0, 0);
    step(1, 16'hAAAA, 1, 0, 0);
    chk("t3_count", 32'(count), 4);
    chk("t3_ovf", 32'(overflow), 0);
    idle(4, 1);
    chk("t3_nseen", 32'(seen.size()), 5);
    if (seen.size() == 5) begin
      chk("t3_first", 32'(seen[0]), 32'h0A01);
      chk("t3_last", 32'(seen[4]), 32'hAAAA);
    end
    seen.delete();
    for (int i = 0; i < 10; i++) begin
      step(1, 16'(i), 1, 0, 0);
      chk("t4_count", 32'(count), 1);
      chk("t4_head", 32'(out_data), i);
    end
    idle(1, 1);
    chk("t4_nseen", 32'(seen.size()), 10);
    if (seen.size() == 10)
      for (int i = 0; i < 10; i++) chk("t4_word", 32'(seen[i]), i);
    for (int i = 0; i < 5; i++) step(1, 16'h0B00 + 16'(i), 0, 0, 0);
    step(0, 0, 1, 0, 0);
    chk("t5_count", 32'(count), 3);
    chk("t5_ovf_set", 32'(overflow), 1);
    step(0, 0, 0, 0, 1);
    chk("t5_count", 32'(count), 0);
    chk("t5_valid", 32'(out_valid), 0);
    chk("t5_ovf", 32'(overflow), 0);
    seen.delete();
    step(1, 16'h00FF, 0, 0, 0);
    idle(1, 1);
    chk("t5_nseen", 32'(seen.size()), 1);
    if (seen.size() == 1) chk("t5_word", 32'(seen[0]), 32'h00FF);
    for (int i = 0; i < 5; i++) step(1, 16'h0C00 + 16'(i), 0, 0, 0);
    chk("t6_ovf", 32'(overflow), 1);
    step(0, 0, 0, 1, 0);
    chk("t6_clr", 32'(overflow), 0);
    step(1, 16'hDEAD, 0, 1, 0);
    chk("t6_setwins", 32'(overflow), 1);
    chk("t6_count", 32'(count), 4);
    idle(5, 1);
    chk("t6_empty", 32'(count), 0);
    chk_en = 0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
